// File: rtl/lut_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lut_phase_ctrl
// Purpose : Phase-index sequencer for the waveform LUTs feeding the R2R DAC.
//           It steps table_count at a programmable rate and selects the active
//           waveform. It holds one pending pitch/waveform config and applies it
//           only at a period boundary, or while idle.
// Revision: 1.0 - initial release
// ============================================================================
module lut_phase_ctrl #(
    parameter int TABLE_LEN = 360,
    parameter int DIV_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_wave,
    output logic [15:0]      table_count,
    output logic [1:0]       wave_sel,
    output logic             lut_en,
    output logic             period_start
);

    localparam logic [15:0]      c_LAST    = 16'(TABLE_LEN - 1);
    localparam logic [DIV_W-1:0] c_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [15:0]      count_q,     count_d;
    logic [DIV_W-1:0] presc_q,     presc_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [1:0]       wave_q,      wave_d;
    logic             pend_full_q, pend_full_d;
    logic [DIV_W-1:0] pend_div_q,  pend_div_d;
    logic [1:0]       pend_wave_q, pend_wave_d;
    logic             pstart_q,    pstart_d;

    logic w_accept;
    logic w_step;
    logic w_wrap;

    // Handshake and step/wrap qualifiers derived from the current state.
    assign w_accept = cfg_valid && !pend_full_q;
    assign w_step   = (presc_q == (div_q - c_DIV_ONE));
    assign w_wrap   = w_step && (count_q == c_LAST);

    // Next-state logic for the FSM, the phase counters and the config buffer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_d     = presc_q;
        div_d       = div_q;
        wave_d      = wave_q;
        pend_full_d = pend_full_q;
        pend_div_d  = pend_div_q;
        pend_wave_d = pend_wave_q;
        pstart_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                presc_d = '0;
                // No waveform is playing, so a pending config can be applied immediately.
                if (pend_full_q) begin
                    div_d       = pend_div_q;
                    wave_d      = pend_wave_q;
                    pend_full_d = 1'b0;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // When en drops on a wrap cycle, the drop takes priority. The
                    // pending config is kept and applied in IDLE instead.
                    state_d = ST_IDLE;
                    count_d = '0;
                    presc_d = '0;
                end else if (w_step) begin
                    presc_d = '0;
                    if (w_wrap) begin
                        count_d  = '0;
                        pstart_d = 1'b1;
                        if (pend_full_q) begin
                            div_d       = pend_div_q;
                            wave_d      = pend_wave_q;
                            pend_full_d = 1'b0;
                        end
                    end else begin
                        count_d = count_q + 16'd1;
                    end
                end else begin
                    presc_d = presc_q + c_DIV_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accepting requires an empty buffer, so it never races an apply.
        // A config accepted on a wrap cycle waits for the next boundary.
        if (w_accept) begin
            pend_full_d = 1'b1;
            pend_div_d  = (cfg_div == '0) ? c_DIV_ONE : cfg_div;
            pend_wave_d = cfg_wave;
        end
    end

    // State register with synchronous reset; a reset also drops any pending config.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            presc_q     <= '0;
            div_q       <= c_DIV_ONE;
            wave_q      <= 2'd0;
            pend_full_q <= 1'b0;
            pend_div_q  <= c_DIV_ONE;
            pend_wave_q <= 2'd0;
            pstart_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            div_q       <= div_d;
            wave_q      <= wave_d;
            pend_full_q <= pend_full_d;
            pend_div_q  <= pend_div_d;
            pend_wave_q <= pend_wave_d;
            pstart_q    <= pstart_d;
        end
    end

    assign table_count  = count_q;
    assign wave_sel     = wave_q;
    assign lut_en       = (state_q == ST_RUN);
    assign period_start = pstart_q;
    assign cfg_ready    = !pend_full_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lut_phase_ctrl
// Purpose : Randomized self-checking bench for lut_phase_ctrl. The reference
//           model tracks elapsed cycles within the current period and derives
//           the phase index as elapsed / div.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lut_phase_ctrl;

    localparam int TABLE_LEN = 360;
    localparam int DIV_W     = 16;
    localparam int NCYC      = 20000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_wave;
    logic [15:0]      table_count;
    logic [1:0]       wave_sel;
    logic             lut_en;
    logic             period_start;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the values the DUT should present after the most recent edge.
    bit m_run;
    int m_t;
    int m_div;
    int m_wave;
    bit m_pfull;
    int m_pdiv;
    int m_pwave;
    bit m_pstart;

    always #5 clk = ~clk;

    lut_phase_ctrl #(
        .TABLE_LEN (TABLE_LEN),
        .DIV_W     (DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_div      (cfg_div),
        .cfg_wave     (cfg_wave),
        .table_count  (table_count),
        .wave_sel     (wave_sel),
        .lut_en       (lut_en),
        .period_start (period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_run    = 1'b0;
        m_t      = 0;
        m_div    = 1;
        m_wave   = 0;
        m_pfull  = 1'b0;
        m_pdiv   = 1;
        m_pwave  = 0;
        m_pstart = 1'b0;
    endfunction

    function automatic bit model_at_wrap();
        return m_run && (m_t == m_div * TABLE_LEN - 1);
    endfunction

    // Advance the model by one clock edge, using the inputs applied during that cycle.
    function automatic void model_step(input bit r, input bit e, input bit cv, input int cd, input int cw);
        bit accept;
        bit wrap;
        if (r) begin
            model_reset();
            return;
        end
        accept   = cv && !m_pfull;
        wrap     = model_at_wrap();
        m_pstart = 1'b0;
        if (!m_run) begin
            if (m_pfull) begin
                m_div   = m_pdiv;
                m_wave  = m_pwave;
                m_pfull = 1'b0;
            end
            m_run = e;
            m_t   = 0;
        end else if (!e) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (wrap) begin
            m_t      = 0;
            m_pstart = 1'b1;
            if (m_pfull) begin
                m_div   = m_pdiv;
                m_wave  = m_pwave;
                m_pfull = 1'b0;
            end
        end else begin
            m_t++;
        end
        if (accept) begin
            m_pfull = 1'b1;
            m_pdiv  = (cd == 0) ? 1 : cd;
            m_pwave = cw;
        end
    endfunction

    initial begin
        int drop_cnt;
        int sel;
        int exp_count;
        drop_cnt  = 0;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_wave  = 2'd0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            exp_count = m_run ? (m_t / m_div) : 0;
            check("table_count",  32'(table_count),  32'(exp_count));
            check("wave_sel",     32'(wave_sel),     32'(m_wave));
            check("lut_en",       32'(lut_en),       32'(m_run));
            check("cfg_ready",    32'(cfg_ready),    32'(!m_pfull));
            check("period_start", 32'(period_start), 32'(m_pstart));

            // Reset: held at start-up, pulsed for two cycles mid-run, and asserted rarely at random.
            rst = (cyc < 2) || (cyc == 1200) || (cyc == 1201) ||
                  ((cyc > 3000) && ($urandom_range(0, 4999) == 0));

            // Run request: off during initial idle configuration, then occasional drops,
            // biased so that some drops land exactly on the wrap cycle.
            if (cyc < 6) begin
                en = 1'b0;
            end else begin
                if (drop_cnt == 0) begin
                    if (($urandom_range(0, 1499) == 0) ||
                        (model_at_wrap() && ($urandom_range(0, 7) == 0)))
                        drop_cnt = $urandom_range(1, 5);
                end
                en = (drop_cnt == 0);
                if (drop_cnt > 0) drop_cnt--;
            end

            // Config offers: one directed offer while idle, then random offers, biased
            // toward the exact wrap cycle. Offers arriving while the buffer is full must be ignored.
            if (cyc == 3) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd2;
                cfg_wave  = 2'd1;
            end else if (cyc < 6) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = ($urandom_range(0, 59) == 0) ||
                            (model_at_wrap() && !m_pfull && ($urandom_range(0, 1) == 1));
                sel = $urandom_range(0, 9);
                if (sel == 0)      cfg_div = '0;
                else if (sel < 8)  cfg_div = DIV_W'(1 + (sel % 3));
                else if (sel == 8) cfg_div = 16'd4;
                else               cfg_div = DIV_W'($urandom_range(5, 12));
                cfg_wave = 2'($urandom_range(0, 3));
            end

            model_step(rst, en, cfg_valid, int'(cfg_div), int'(cfg_wave));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
